mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-ported unified memory between the instruction-fetch (IF) and load/store (LSU) ports of the 5-stage RISCV core. One transaction is outstanding at a time. LSU has priority, with a starvation guard for IF. Per-requester stall outputs hold the corresponding pipeline stage until its response returns, alongside the hazard stall logic.

## Interface
- STARVE_LIMIT, 4: consecutive LSU grants tolerated while IF is waiting; the next arbitration then goes to IF (legal range 1..15).
- TIMEOUT_CYCLES, 64: cycles allowed in ARB_ADDR+ARB_RESP before abort (used only with the watchdog compiled in).
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- IF_req_ip  input  1  fetch request; held until IF_rvalid_op.
- IF_addr_ip  input  32  fetch address; stable while IF_req_ip is high.
- LSU_req_ip  input  1  load/store request; held until LSU_rvalid_op.
- LSU_addr_ip  input  32  data address.
- LSU_we_ip  input  1  1 = store.
- LSU_be_ip  input  4  byte enables.
- LSU_wdata_ip  input  32  store data.
- mem_req_op  output  1  memory address-phase request.
- mem_addr_op  output  32  owner's address.
- mem_we_op  output  1  LSU_we_ip when the owner is LSU, else 0.
- mem_be_op  output  4  LSU_be_ip when the owner is LSU, else 4'hF.
- mem_wdata_op  output  32  LSU_wdata_ip.
- mem_gnt_ip  input  1  memory accepted the address phase.
- mem_rvalid_ip  input  1  response/completion, including for stores.
- mem_rdata_ip  input  32  read data.
- rdata_op  output  32  mem_rdata_ip broadcast to both requesters.
- IF_rvalid_op / LSU_rvalid_op  output  1  one-cycle response pulse to the owner.
- IF_stall_op / LSU_stall_op  output  1  req && !rvalid for that port.
- timeout_err_op  output  1  sticky watchdog error flag.

## Operation
- FSM states: ARB_IDLE → ARB_ADDR → ARB_RESP → ARB_IDLE.
- ARB_IDLE, arbitration:
  - If only one port requests, that port wins.
  - If both request, LSU wins unless starve_cnt == STARVE_LIMIT, in which case IF wins.
  - The winner is latched into the owner register; next state is ARB_ADDR. With no request, stay in ARB_IDLE.
- ARB_ADDR: mem_req_op = 1. The mem_* outputs are combinationally muxed from the owner's inputs. On mem_gnt_ip → ARB_RESP.
- ARB_RESP: mem_req_op = 0. On mem_rvalid_ip, pulse the owner's rvalid in the same cycle → ARB_IDLE.
- starve_cnt:
  - Increments when LSU is granted while IF_req_ip = 1, saturating at STARVE_LIMIT.
  - Clears to 0 on any IF grant, or on an LSU grant with IF idle.
- Stall outputs are combinational and depend only on req and rvalid, so a stalled stage releases in the same cycle its response arrives.
- Requester drops req mid-transaction (protocol violation): the transaction still completes and the rvalid pulse is still issued. No abort.
- mem_rvalid_ip outside ARB_RESP is ignored and produces no pulse.
- mem_gnt_ip and mem_rvalid_ip in the same ARB_ADDR cycle: go to ARB_RESP only; the memory must not respond before the grant cycle ends.
- Reset, including mid-transaction:
  - State immediately returns to ARB_IDLE, with owner = IF, starve_cnt = 0 and the watchdog cleared.
  - All outputs read 0 except mem_be_op = 4'hF, which follows the IF-owner default; rdata_op follows mem_rdata_ip.

## Timing
- Minimum transaction latency is 3 cycles: req seen at cycle 0 (IDLE), mem_req_op at cycle 1 with grant, rvalid at cycle 2, IDLE at cycle 3.
- Back-to-back transactions therefore take at most one per 3 cycles; there is one IDLE bubble between transactions.
- Arbitration uses only ARB_IDLE-cycle inputs; a request raised during a busy transaction waits for the next IDLE.
- Each memory wait cycle adds exactly one cycle of latency and one stall cycle.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - A counter runs while the FSM is in ARB_ADDR or ARB_RESP and clears in IDLE.
  - On reaching TIMEOUT_CYCLES: force ARB_IDLE, pulse the owner's rvalid with rdata_op = 0 in that cycle, and set timeout_err_op. It stays set until reset.
- MEM_ARB_TIMEOUT_EN undefined: no counter; timeout_err_op is tied to 0 and the port is kept.

## Structure
- CORE_PKG gains:
  - arb_state_t enum {ARB_IDLE, ARB_ADDR, ARB_RESP};
  - arb_owner_t enum {OWNER_IF, OWNER_LSU};
  - MEM_ARB_BE_FULL = 4'hF.
- Sub-module mem_arb_watchdog: counter plus sticky error flag, instantiated only under MEM_ARB_TIMEOUT_EN.

## Test plan
- IF-only read at 0x100, gnt in cycle 1, rvalid in cycle 2: IF_rvalid_op pulses in cycle 2, IF_stall_op = 1 in cycles 0–1, mem_be_op = 4'hF.
- IF and LSU request together at reset release (LSU store to 0x2000, be = 4'b0011, wdata = 0xDEADBEEF): LSU is served first with mem_we_op = 1 and exact be/wdata; IF is granted at the next IDLE.
- LSU requests continuously with IF pending, STARVE_LIMIT = 4: grant order is LSU×4, then IF, then LSU.
- Memory inserts 5 gnt wait cycles and 3 rvalid wait cycles: latency is 11 cycles and stall is held exactly until the rvalid cycle.
- reset asserted in ARB_RESP: outputs drop immediately; a stray mem_rvalid_ip after reset produces no rvalid pulse.
- MEM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES = 8 and the memory never granting: owner rvalid pulses in the 8th busy cycle with rdata_op = 0, and timeout_err_op is set and stays at 1.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared types and constants for the unified-memory port arbiter that sits
// between the instruction-fetch (IF) and load/store (LSU) ports of the core.
//   arb_state_t     : arbiter FSM state (idle / address phase / response wait)
//   arb_owner_t     : which requester owns the in-flight transaction
//   MEM_ARB_BE_FULL : byte-enable pattern presented for instruction fetches
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_IF  = 1'b0,
        OWNER_LSU = 1'b1
    } arb_owner_t;

    localparam logic [3:0] MEM_ARB_BE_FULL = 4'hF;

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// -----------------------------------------------------------------------------
// mem_arb_watchdog
// Busy-cycle counter with a sticky error flag. Only compiled when the
// MEM_ARB_TIMEOUT_EN macro is defined; the arbiter instantiates it under the
// same macro.
// Ports:
//   clk     : core clock
//   reset   : asynchronous, active-low reset
//   busy    : arbiter is in its address or response phase
//   expire  : combinational, high in the TIMEOUT_CYCLES-th consecutive busy cycle
//   err     : sticky, set the cycle after expire, cleared only by reset
// -----------------------------------------------------------------------------
`ifdef MEM_ARB_TIMEOUT_EN
module mem_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic busy,
    output logic expire,
    output logic err
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // cnt holds the number of busy cycles already elapsed, so the
    // TIMEOUT_CYCLES-th busy cycle sees cnt == TIMEOUT_CYCLES-1.
    assign expire = busy && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= (busy && !expire) ? cnt + 1'b1 : '0;
            if (expire) begin
                err <= 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single-ported unified memory between the IF and LSU ports.
// One transaction in flight at a time; LSU has priority, but after
// STARVE_LIMIT consecutive LSU grants with IF waiting, IF wins the next
// arbitration. Optional watchdog (macro MEM_ARB_TIMEOUT_EN) aborts a
// transaction that stays busy for TIMEOUT_CYCLES cycles.
// Ports:
//   clk, reset                 : clock, asynchronous active-low reset
//   IF_req_ip / IF_addr_ip     : fetch request and address
//   LSU_req_ip / LSU_addr_ip / LSU_we_ip / LSU_be_ip / LSU_wdata_ip
//                              : load/store request, address, write enable,
//                                byte enables and store data
//   mem_req_op / mem_addr_op / mem_we_op / mem_be_op / mem_wdata_op
//                              : memory address phase, muxed from the owner
//   mem_gnt_ip / mem_rvalid_ip / mem_rdata_ip
//                              : memory grant, completion and read data
//   rdata_op                   : read data broadcast to both requesters
//   IF_rvalid_op / LSU_rvalid_op : one-cycle completion pulse to the owner
//   IF_stall_op / LSU_stall_op : hold the requesting stage until completion
//   timeout_err_op             : sticky watchdog error (0 without the macro)
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IF_req_ip,
    input  logic [31:0] IF_addr_ip,
    input  logic        LSU_req_ip,
    input  logic [31:0] LSU_addr_ip,
    input  logic        LSU_we_ip,
    input  logic [3:0]  LSU_be_ip,
    input  logic [31:0] LSU_wdata_ip,
    output logic        mem_req_op,
    output logic [31:0] mem_addr_op,
    output logic        mem_we_op,
    output logic [3:0]  mem_be_op,
    output logic [31:0] mem_wdata_op,
    input  logic        mem_gnt_ip,
    input  logic        mem_rvalid_ip,
    input  logic [31:0] mem_rdata_ip,
    output logic [31:0] rdata_op,
    output logic        IF_rvalid_op,
    output logic        LSU_rvalid_op,
    output logic        IF_stall_op,
    output logic        LSU_stall_op,
    output logic        timeout_err_op
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("mem_port_arbiter: STARVE_LIMIT must be 1..15 and TIMEOUT_CYCLES >= 2");
    end

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    arb_state_t state;
    arb_owner_t owner;
    logic [3:0] starve_cnt;
    logic       if_wins;
    logic       abort;
    logic       rsp_pulse;

    // IF wins when it is alone, or when LSU has starved it long enough.
    assign if_wins = IF_req_ip && (!LSU_req_ip || (starve_cnt == STARVE_MAX));

`ifdef MEM_ARB_TIMEOUT_EN
    logic busy;
    assign busy = (state != ARB_IDLE);

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .busy   (busy),
        .expire (abort),
        .err    (timeout_err_op)
    );
`else
    assign abort          = 1'b0;
    assign timeout_err_op = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ARB_IDLE;
            owner      <= OWNER_IF;
            starve_cnt <= '0;
        end else if (abort) begin
            state <= ARB_IDLE;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (IF_req_ip || LSU_req_ip) begin
                        state <= ARB_ADDR;
                        if (if_wins) begin
                            owner      <= OWNER_IF;
                            starve_cnt <= '0;
                        end else begin
                            owner <= OWNER_LSU;
                            if (!IF_req_ip) begin
                                starve_cnt <= '0;
                            end else if (starve_cnt < STARVE_MAX) begin
                                starve_cnt <= starve_cnt + 4'd1;
                            end
                        end
                    end
                end
                // A same-cycle rvalid alongside the grant is deliberately ignored.
                ARB_ADDR: if (mem_gnt_ip)    state <= ARB_RESP;
                ARB_RESP: if (mem_rvalid_ip) state <= ARB_IDLE;
                default:                     state <= ARB_IDLE;
            endcase
        end
    end

    // Address and store data are forced to 0 while reset is held so that
    // nothing leaks onto the memory bus from requesters that keep driving.
    assign mem_req_op   = (state == ARB_ADDR);
    assign mem_addr_op  = !reset ? '0 : ((owner == OWNER_LSU) ? LSU_addr_ip : IF_addr_ip);
    assign mem_we_op    = (owner == OWNER_LSU) && LSU_we_ip;
    assign mem_be_op    = (owner == OWNER_LSU) ? LSU_be_ip : MEM_ARB_BE_FULL;
    assign mem_wdata_op = !reset ? '0 : LSU_wdata_ip;

    // A watchdog abort completes the transaction with zero data.
    assign rdata_op      = abort ? '0 : mem_rdata_ip;
    assign rsp_pulse     = ((state == ARB_RESP) && mem_rvalid_ip) || abort;
    assign IF_rvalid_op  = rsp_pulse && (owner == OWNER_IF);
    assign LSU_rvalid_op = rsp_pulse && (owner == OWNER_LSU);

    // Stalls release combinationally in the response cycle.
    assign IF_stall_op  = reset && IF_req_ip  && !IF_rvalid_op;
    assign LSU_stall_op = reset && LSU_req_ip && !LSU_rvalid_op;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int STARVE_LIMIT   = 4;
    localparam int TIMEOUT_CYCLES = 8;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int GW = 3;
    localparam int RW = 2;
`else
    localparam int GW = 5;
    localparam int RW = 3;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        IF_req_ip;
    logic [31:0] IF_addr_ip;
    logic        LSU_req_ip;
    logic [31:0] LSU_addr_ip;
    logic        LSU_we_ip;
    logic [3:0]  LSU_be_ip;
    logic [31:0] LSU_wdata_ip;
    logic        mem_req_op;
    logic [31:0] mem_addr_op;
    logic        mem_we_op;
    logic [3:0]  mem_be_op;
    logic [31:0] mem_wdata_op;
    logic        mem_gnt_ip;
    logic        mem_rvalid_ip;
    logic [31:0] mem_rdata_ip;
    logic [31:0] rdata_op;
    logic        IF_rvalid_op;
    logic        LSU_rvalid_op;
    logic        IF_stall_op;
    logic        LSU_stall_op;
    logic        timeout_err_op;

    mem_port_arbiter #(
        .STARVE_LIMIT   (STARVE_LIMIT),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .IF_req_ip      (IF_req_ip),
        .IF_addr_ip     (IF_addr_ip),
        .LSU_req_ip     (LSU_req_ip),
        .LSU_addr_ip    (LSU_addr_ip),
        .LSU_we_ip      (LSU_we_ip),
        .LSU_be_ip      (LSU_be_ip),
        .LSU_wdata_ip   (LSU_wdata_ip),
        .mem_req_op     (mem_req_op),
        .mem_addr_op    (mem_addr_op),
        .mem_we_op      (mem_we_op),
        .mem_be_op      (mem_be_op),
        .mem_wdata_op   (mem_wdata_op),
        .mem_gnt_ip     (mem_gnt_ip),
        .mem_rvalid_ip  (mem_rvalid_ip),
        .mem_rdata_ip   (mem_rdata_ip),
        .rdata_op       (rdata_op),
        .IF_rvalid_op   (IF_rvalid_op),
        .LSU_rvalid_op  (LSU_rvalid_op),
        .IF_stall_op    (IF_stall_op),
        .LSU_stall_op   (LSU_stall_op),
        .timeout_err_op (timeout_err_op)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_lsu;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } txn_t;

    txn_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   lat;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic stall_of(input logic lsu);
        return lsu ? LSU_stall_op : IF_stall_op;
    endfunction

    function automatic logic rvalid_of(input logic lsu);
        return lsu ? LSU_rvalid_op : IF_rvalid_op;
    endfunction

    function automatic logic req_of(input logic lsu);
        return lsu ? LSU_req_ip : IF_req_ip;
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_txn(input logic lsu, input logic [31:0] a, input logic we,
                              input logic [3:0] be, input logic [31:0] wd);
        txn_t t;
        t.is_lsu = lsu;
        t.addr   = a;
        t.we     = we;
        t.be     = be;
        t.wdata  = wd;
        exp_q.push_back(t);
    endtask

    // Plays the memory for one transaction, starting in an IDLE cycle.
    // lat = cycles from that IDLE cycle to the rvalid cycle.
    task automatic serve(input int gw, input int rw, output int latency);
        txn_t        t;
        int          n;
        logic [31:0] rd;
        latency = 0;
        n = 0;
        #1;
        while (mem_req_op !== 1'b1 && n < 8) begin
            tick(); #1;
            n++;
            latency++;
        end
        if (mem_req_op !== 1'b1) begin
            check1("addr_phase_timeout", mem_req_op, 1'b1);
            return;
        end
        if (exp_q.size() == 0) begin
            check32("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
            return;
        end
        t = exp_q.pop_front();
        for (int i = 0; i < gw; i++) begin
            mem_gnt_ip = 1'b0; #1;
            check1("stall_gnt_wait", stall_of(t.is_lsu), 1'b1);
            check1("req_gnt_wait", mem_req_op, 1'b1);
            tick(); #1;
            latency++;
        end
        mem_gnt_ip = 1'b1; #1;
        check1("mem_req", mem_req_op, 1'b1);
        check32("mem_addr", mem_addr_op, t.addr);
        check1("mem_we", mem_we_op, t.we);
        check32("mem_be", 32'(mem_be_op), 32'(t.be));
        if (t.is_lsu) check32("mem_wdata", mem_wdata_op, t.wdata);
        check1("stall_owner", stall_of(t.is_lsu), 1'b1);
        check1("stall_other", stall_of(!t.is_lsu), req_of(!t.is_lsu));
        tick();
        mem_gnt_ip = 1'b0; #1;
        latency++;
        check1("mem_req_resp", mem_req_op, 1'b0);
        for (int i = 0; i < rw; i++) begin
            mem_rvalid_ip = 1'b0; #1;
            check1("stall_rvalid_wait", stall_of(t.is_lsu), 1'b1);
            check1("no_early_rvalid", rvalid_of(t.is_lsu), 1'b0);
            tick(); #1;
            latency++;
        end
        rd = mem_model(t.addr);
        mem_rdata_ip  = rd;
        mem_rvalid_ip = 1'b1; #1;
        check1("rvalid_owner", rvalid_of(t.is_lsu), 1'b1);
        check1("rvalid_other", rvalid_of(!t.is_lsu), 1'b0);
        check32("rdata", rdata_op, rd);
        check1("stall_release", stall_of(t.is_lsu), 1'b0);
        tick();
        mem_rvalid_ip = 1'b0; #1;
        check1("rvalid_single", rvalid_of(t.is_lsu), 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset         = 1'b0;
        IF_req_ip     = 1'b1;
        IF_addr_ip    = 32'h0000_1000;
        LSU_req_ip    = 1'b1;
        LSU_addr_ip   = 32'h0000_2000;
        LSU_we_ip     = 1'b1;
        LSU_be_ip     = 4'b0011;
        LSU_wdata_ip  = 32'hDEAD_BEEF;
        mem_gnt_ip    = 1'b0;
        mem_rvalid_ip = 1'b0;
        mem_rdata_ip  = 32'h1111_2222;
        repeat (3) tick();
        #1;
        check1("rst_mem_req", mem_req_op, 1'b0);
        check32("rst_mem_addr", mem_addr_op, 32'h0);
        check1("rst_mem_we", mem_we_op, 1'b0);
        check32("rst_mem_be", 32'(mem_be_op), 32'hF);
        check32("rst_mem_wdata", mem_wdata_op, 32'h0);
        check32("rst_rdata_follow", rdata_op, 32'h1111_2222);
        check1("rst_if_stall", IF_stall_op, 1'b0);
        check1("rst_lsu_stall", LSU_stall_op, 1'b0);
        check1("rst_if_rvalid", IF_rvalid_op, 1'b0);
        check1("rst_lsu_rvalid", LSU_rvalid_op, 1'b0);
        check1("rst_timeout_err", timeout_err_op, 1'b0);

        // Both request at reset release: LSU store first, then IF
        tick();
        reset = 1'b1;
        expect_txn(1'b1, 32'h0000_2000, 1'b1, 4'b0011, 32'hDEAD_BEEF);
        expect_txn(1'b0, 32'h0000_1000, 1'b0, 4'hF, 32'h0);
        serve(0, 0, lat);
        check32("lsu_first_latency", 32'(lat), 32'd2);
        LSU_req_ip = 1'b0;
        serve(0, 0, lat);
        check32("if_next_idle_latency", 32'(lat), 32'd2);
        IF_req_ip = 1'b0;

        // IF-only read, minimum latency
        IF_req_ip  = 1'b1;
        IF_addr_ip = 32'h0000_0100;
        #1;
        check1("if_stall_cycle0", IF_stall_op, 1'b1);
        check1("lsu_stall_idle", LSU_stall_op, 1'b0);
        expect_txn(1'b0, 32'h0000_0100, 1'b0, 4'hF, 32'h0);
        serve(0, 0, lat);
        check32("if_only_latency", 32'(lat), 32'd2);
        IF_req_ip = 1'b0;

        // Starvation guard: LSU x4, IF, LSU
        IF_req_ip  = 1'b1;
        IF_addr_ip = 32'h0000_2400;
        LSU_req_ip = 1'b1;
        for (int k = 0; k < STARVE_LIMIT; k++) begin
            LSU_addr_ip  = 32'h0000_3000 + 32'(k * 4);
            LSU_we_ip    = k[0];
            LSU_be_ip    = 4'b0001 << k;
            LSU_wdata_ip = 32'hA000_0000 + 32'(k);
            expect_txn(1'b1, LSU_addr_ip, LSU_we_ip, LSU_be_ip, LSU_wdata_ip);
            serve(0, 0, lat);
        end
        LSU_addr_ip  = 32'h0000_3010;
        LSU_we_ip    = 1'b0;
        LSU_be_ip    = 4'b1100;
        LSU_wdata_ip = 32'h5555_AAAA;
        expect_txn(1'b0, 32'h0000_2400, 1'b0, 4'hF, 32'h0);
        serve(0, 0, lat);
        IF_req_ip = 1'b0;
        expect_txn(1'b1, 32'h0000_3010, 1'b0, 4'b1100, 32'h5555_AAAA);
        serve(0, 0, lat);
        LSU_req_ip = 1'b0;

        // Memory wait states: latency grows one cycle per wait
        IF_req_ip  = 1'b1;
        IF_addr_ip = 32'h0000_0500;
        expect_txn(1'b0, 32'h0000_0500, 1'b0, 4'hF, 32'h0);
        serve(GW, RW, lat);
        check32("wait_latency", 32'(lat), 32'(GW + RW + 2));
        IF_req_ip = 1'b0;

        // Reset asserted while an LSU store waits in the response phase
        LSU_req_ip   = 1'b1;
        LSU_addr_ip  = 32'h0000_4000;
        LSU_we_ip    = 1'b1;
        LSU_be_ip    = 4'b0011;
        LSU_wdata_ip = 32'hCAFE_F00D;
        tick(); #1;
        check1("rst_test_addr_phase", mem_req_op, 1'b1);
        check32("rst_test_lsu_be", 32'(mem_be_op), 32'h3);
        mem_gnt_ip = 1'b1;
        tick();
        mem_gnt_ip = 1'b0; #1;
        check1("rst_test_resp_phase", mem_req_op, 1'b0);
        check1("rst_test_lsu_stall", LSU_stall_op, 1'b1);
        reset         = 1'b0;
        mem_rvalid_ip = 1'b1;
        mem_rdata_ip  = 32'h7777_8888;
        #1;
        check1("midrst_mem_req", mem_req_op, 1'b0);
        check1("midrst_lsu_rvalid", LSU_rvalid_op, 1'b0);
        check1("midrst_if_rvalid", IF_rvalid_op, 1'b0);
        check1("midrst_lsu_stall", LSU_stall_op, 1'b0);
        check32("midrst_mem_be", 32'(mem_be_op), 32'hF);
        check1("midrst_mem_we", mem_we_op, 1'b0);
        check32("midrst_mem_addr", mem_addr_op, 32'h0);
        check32("midrst_mem_wdata", mem_wdata_op, 32'h0);
        check32("midrst_rdata_follow", rdata_op, 32'h7777_8888);
        tick();
        LSU_req_ip = 1'b0;
        reset      = 1'b1;
        #1;
        check1("stray_rvalid_lsu", LSU_rvalid_op, 1'b0);
        check1("stray_rvalid_if", IF_rvalid_op, 1'b0);
        tick(); #1;
        check1("stray_rvalid_lsu_2", LSU_rvalid_op, 1'b0);
        check1("stray_idle", mem_req_op, 1'b0);
        mem_rvalid_ip = 1'b0;
        IF_req_ip     = 1'b1;
        IF_addr_ip    = 32'h0000_0700;
        expect_txn(1'b0, 32'h0000_0700, 1'b0, 4'hF, 32'h0);
        serve(0, 0, lat);
        check32("post_reset_latency", 32'(lat), 32'd2);
        IF_req_ip = 1'b0;

`ifdef MEM_ARB_TIMEOUT_EN
        // Memory never grants: watchdog aborts in the last busy cycle
        IF_req_ip    = 1'b1;
        IF_addr_ip   = 32'h0000_0800;
        mem_rdata_ip = 32'hFFFF_FFFF;
        for (int i = 1; i <= TIMEOUT_CYCLES; i++) begin
            tick(); #1;
            if (i < TIMEOUT_CYCLES) check1("wd_no_early_pulse", IF_rvalid_op, 1'b0);
        end
        check1("wd_rvalid", IF_rvalid_op, 1'b1);
        check32("wd_rdata_zero", rdata_op, 32'h0);
        tick();
        IF_req_ip = 1'b0;
        #1;
        check1("wd_err_set", timeout_err_op, 1'b1);
        check1("wd_idle", mem_req_op, 1'b0);
        repeat (3) tick();
        #1;
        check1("wd_err_sticky", timeout_err_op, 1'b1);
`else
        check1("timeout_err_tied", timeout_err_op, 1'b0);
`endif

        check32("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
